// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM counter / compare / dead-time path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int COUNTER_WIDTH_DEFAULT  = 16;
  localparam int DEADTIME_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_ON    = 3'd1,
    DT_TO_B = 3'd2,
    B_ON    = 3'd3,
    DT_TO_A = 3'd4
  } pwm_cmp_state_t;

  // True for the two both-outputs-off dead-time states.
  function automatic logic is_deadtime(input pwm_cmp_state_t s);
    return (s == DT_TO_A) || (s == DT_TO_B);
  endfunction

endpackage

// File: rtl/deadtime_timer.sv
// Dead-time down-counter: loads a value, decrements on timebase ticks, saturates at zero.
// Latency: load visible one clock after the load edge; zero flag is combinational from count.
// Backpressure: none; load always wins over decrement.
module deadtime_timer #(
  parameter int DEADTIME_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DEADTIME_WIDTH-1:0] load_value,
  input  logic                      timebase,
  output logic [DEADTIME_WIDTH-1:0] count,
  output logic                      zero
);

  assign zero = (count == '0);

  // Load on request, otherwise count down on ticks and hold at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (timebase && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pwm_compare_deadtime.sv
// Window compare on the PWM count driving a complementary A/B pair with dead-time insertion.
// Latency: 2 clocks from count_in to outputs (raw compare reg, then state/output reg) plus dead-time.
// Backpressure: none; enable low forces IDLE with both outputs off on the next edge.
module pwm_compare_deadtime
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEFAULT,
  parameter int DEADTIME_WIDTH = DEADTIME_WIDTH_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      timebase,
  input  logic [COUNTER_WIDTH-1:0]  count_in,
  input  logic                      reload_compare,
  input  logic [COUNTER_WIDTH-1:0]  compare_low_data,
  input  logic [COUNTER_WIDTH-1:0]  compare_high_data,
  input  logic [DEADTIME_WIDTH-1:0] deadtime_data,
  output logic                      pwm_out_a,
  output logic                      pwm_out_b,
  output logic                      shadow_loaded
);

  logic                      enable_q;
  logic                      load_shadow;
  logic [COUNTER_WIDTH-1:0]  cmp_low_s;
  logic [COUNTER_WIDTH-1:0]  cmp_high_s;
  logic [DEADTIME_WIDTH-1:0] deadtime_s;
  logic                      raw;
  pwm_cmp_state_t            state;
  pwm_cmp_state_t            state_nxt;
  logic                      timer_load;
  logic [DEADTIME_WIDTH-1:0] timer_value;
  logic [DEADTIME_WIDTH-1:0] dt_count;
  logic                      dt_zero;
  logic                      a_nxt;
  logic                      b_nxt;

  // Shadows take new thresholds at counter zero or on the first enabled cycle only.
  assign load_shadow = enable && (reload_compare || !enable_q);

  // Shadow registers, their load strobe and the enable history used to spot a rising enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_q      <= 1'b0;
      shadow_loaded <= 1'b0;
      cmp_low_s     <= '0;
      cmp_high_s    <= '0;
      deadtime_s    <= '0;
    end else begin
      enable_q      <= enable;
      shadow_loaded <= load_shadow;
      if (load_shadow) begin
        cmp_low_s  <= compare_low_data;
        cmp_high_s <= compare_high_data;
        deadtime_s <= deadtime_data;
      end
    end
  end

  // Registered window compare; an empty or inverted window never matches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raw <= 1'b0;
    end else begin
      raw <= (count_in >= cmp_low_s) && (count_in < cmp_high_s);
    end
  end

  // Reload on every fresh entry into a dead-time state (including an abort to the other
  // side); clear when disabled so a re-enable never inherits a stale count.
  assign timer_load  = !enable || (is_deadtime(state_nxt) && (state_nxt != state));
  assign timer_value = enable ? deadtime_s : '0;

  deadtime_timer #(
    .DEADTIME_WIDTH (DEADTIME_WIDTH)
  ) u_deadtime_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .timebase   (timebase),
    .count      (dt_count),
    .zero       (dt_zero)
  );

  // State and outputs; outputs are the registered decode of the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pwm_out_a <= 1'b0;
      pwm_out_b <= 1'b0;
    end else begin
      state     <= state_nxt;
      pwm_out_a <= a_nxt;
      pwm_out_b <= b_nxt;
    end
  end

  // Next-state: disable wins, dead-time can abort to the opposite side at any point.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = raw ? DT_TO_A : DT_TO_B;
        A_ON:    if (!raw) state_nxt = DT_TO_B;
        B_ON:    if (raw)  state_nxt = DT_TO_A;
        DT_TO_B: begin
          if (raw)          state_nxt = DT_TO_A;
          else if (dt_zero) state_nxt = B_ON;
        end
        DT_TO_A: begin
          if (!raw)         state_nxt = DT_TO_B;
          else if (dt_zero) state_nxt = A_ON;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: each side only in its own steady state, so A and B are exclusive.
  always_comb begin
    a_nxt = (state_nxt == A_ON);
    b_nxt = (state_nxt == B_ON);
  end

  // The timer is only ever nonzero while a dead-time interval is in progress.
  timer_idle_zero: assert property (@(posedge clock) disable iff (!reset)
    !is_deadtime(state) |-> (dt_count == '0));

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Self-checking bench for pwm_compare_deadtime: vector table plus multi-cycle sequences.
// Latency: expectations are the outputs sampled 1 time unit after the edge that took the vector.
// Backpressure: n/a.
module tb_pwm_compare_deadtime;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        timebase;
  logic [15:0] count_in;
  logic        reload_compare;
  logic [15:0] compare_low_data;
  logic [15:0] compare_high_data;
  logic [7:0]  deadtime_data;
  logic        pwm_out_a;
  logic        pwm_out_b;
  logic        shadow_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        en;
    logic        tb;
    logic        rl;
    logic [15:0] cnt;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [7:0]  dt;
    logic        ea;
    logic        eb;
    logic        es;
  } vec_t;

  vec_t vecs[$];

  pwm_compare_deadtime #(
    .COUNTER_WIDTH  (16),
    .DEADTIME_WIDTH (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .timebase          (timebase),
    .count_in          (count_in),
    .reload_compare    (reload_compare),
    .compare_low_data  (compare_low_data),
    .compare_high_data (compare_high_data),
    .deadtime_data     (deadtime_data),
    .pwm_out_a         (pwm_out_a),
    .pwm_out_b         (pwm_out_b),
    .shadow_loaded     (shadow_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic tb, input logic rl, input int cnt,
                     input int lo, input int hi, input int dt,
                     input logic ea, input logic eb, input logic es);
    vec_t v;
    v.en = en; v.tb = tb; v.rl = rl;
    v.cnt = 16'(cnt); v.lo = 16'(lo); v.hi = 16'(hi); v.dt = 8'(dt);
    v.ea = ea; v.eb = eb; v.es = es;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic en, input logic tb, input logic rl, input int cnt,
                      input int lo, input int hi, input int dt);
    @(negedge clock);
    enable            = en;
    timebase          = tb;
    reload_compare    = rl;
    count_in          = 16'(cnt);
    compare_low_data  = 16'(lo);
    compare_high_data = 16'(hi);
    deadtime_data     = 8'(dt);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int first_a, b_fall, a_fall, b_rise, overlaps, sl_count, both_low;
    logic b_seen;

    reset = 1'b0; enable = 1'b0; timebase = 1'b0; count_in = '0; reload_compare = 1'b0;
    compare_low_data = '0; compare_high_data = '0; deadtime_data = '0;

    // en tb rl  cnt  lo   hi   dt   a b sl
    add(1,1,0,   0, 10,  20,  2,  0,0,1); // v0 first enable: load, IDLE->DT_TO_B with old dt 0
    add(1,1,0,   0, 10,  20,  2,  0,1,0);
    add(1,1,0,  10, 10,  20,  2,  0,1,0);
    add(1,1,0,  10, 10,  20,  2,  0,0,0); // B->DT_TO_A, dt=2
    add(1,1,0,  11, 10,  20,  2,  0,0,0);
    add(1,1,0,  11, 10,  20,  2,  0,0,0);
    add(1,1,0,  11, 10,  20,  2,  1,0,0); // 3 both-low clocks, A on
    add(1,1,0,  20, 10,  20,  2,  1,0,0); // high bound is exclusive
    add(1,1,0,  20, 10,  20,  2,  0,0,0); // DT_TO_B
    add(1,0,0,  20, 10,  20,  2,  0,0,0); // sparse timebase
    add(1,1,0,  20, 10,  20,  2,  0,0,0);
    add(1,0,0,  20, 10,  20,  2,  0,0,0);
    add(1,1,0,  20, 10,  20,  2,  0,0,0);
    add(1,0,0,  20, 10,  20,  2,  0,1,0); // zero exit does not need a tick
    add(1,1,0,   5,  3,  20,  2,  0,1,0); // low=3 written mid-period: ignored
    add(1,1,0,   5,  3,  20,  2,  0,1,0);
    add(1,1,1,   5,  3,  20,  2,  0,1,1); // reload: shadow load pulse
    add(1,1,0,   5,  3,  20,  2,  0,1,0); // raw now 1 with new low
    add(1,1,0,   5,  3,  20,  2,  0,0,0); // DT_TO_A
    add(1,1,0,  25,  3,  20,  2,  0,0,0);
    add(1,1,0,   5,  3,  20,  2,  0,0,0); // abort to DT_TO_B
    add(1,1,0,   5,  3,  20,  2,  0,0,0); // abort back to DT_TO_A, reload
    add(1,1,0,   5,  3,  20,  2,  0,0,0);
    add(1,1,0,   5,  3,  20,  2,  0,0,0);
    add(1,1,0,   5,  3,  20,  2,  1,0,0);
    add(0,1,0,   5,  3,  20,  2,  0,0,0); // enable drop mid A_ON
    add(1,1,1,   5,100, 200,  1,  0,0,1); // re-enable with reload: one pulse
    add(1,1,0,   5,100, 200,  1,  0,0,0);
    add(1,1,0,   5,100, 200,  1,  0,0,0);
    add(1,1,0,   5,100, 200,  1,  0,0,0);
    add(1,1,0,   5,100, 200,  1,  0,1,0);
    add(1,1,1, 300,600, 200,  0,  0,1,1); // degenerate window
    add(1,1,0, 300,600, 200,  0,  0,1,0);
    add(1,1,0, 700,600, 200,  0,  0,1,0);
    add(1,1,0, 150,600, 200,  0,  0,1,0);
    add(1,1,1,  15, 10,  20,  0,  0,1,1); // zero dead-time
    add(1,1,0,  15, 10,  20,  0,  0,1,0);
    add(1,1,0,  15, 10,  20,  0,  0,0,0);
    add(1,1,0,  15, 10,  20,  0,  1,0,0);
    add(1,1,0,  25, 10,  20,  0,  1,0,0);
    add(1,1,0,  25, 10,  20,  0,  0,0,0);
    add(1,1,0,  25, 10,  20,  0,  0,1,0);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset.a", pwm_out_a, 0);
    check("reset.b", pwm_out_b, 0);
    check("reset.sl", shadow_loaded, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].tb, vecs[i].rl, vecs[i].cnt, vecs[i].lo, vecs[i].hi, vecs[i].dt);
      check($sformatf("vec%0d.a", i), pwm_out_a, vecs[i].ea);
      check($sformatf("vec%0d.b", i), pwm_out_b, vecs[i].eb);
      check($sformatf("vec%0d.sl", i), shadow_loaded, vecs[i].es);
    end

    // Async reset while B is on: outputs clear before any clock edge.
    @(negedge clock);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_reset.a", pwm_out_a, 0);
    check("async_reset.b", pwm_out_b, 0);
    check("async_reset.sl", shadow_loaded, 0);
    @(negedge clock);
    reset = 1'b1;

    // Basic window: ramp 0..999, low 200, high 600, dead-time 5.
    first_a = -1; b_fall = -1; a_fall = -1; b_rise = -1;
    overlaps = 0; sl_count = 0; b_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 1, (i == 0), i, 200, 600, 5);
      if (pwm_out_a && pwm_out_b) overlaps++;
      if (shadow_loaded) sl_count++;
      if (pwm_out_b) b_seen = 1'b1;
      if (b_seen && !pwm_out_b && b_fall < 0) b_fall = i;
      if (pwm_out_a && first_a < 0) first_a = i;
      if (first_a >= 0 && !pwm_out_a && a_fall < 0) a_fall = i;
      if (a_fall >= 0 && pwm_out_b && b_rise < 0) b_rise = i;
    end
    check("ramp.b_fall_count", b_fall, 201);
    check("ramp.a_rise_count", first_a, 207);
    check("ramp.a_fall_count", a_fall, 601);
    check("ramp.b_rise_count", b_rise, 607);
    check("ramp.overlaps", overlaps, 0);
    check("ramp.shadow_pulses", sl_count, 1);

    // Load dead-time 10 and move into the window: 11 both-low clocks before A.
    first_a = -1;
    for (int k = 1; k <= 21; k++) begin
      step(1, 1, (k == 1), 300, 200, 600, 10);
      if (pwm_out_a && first_a < 0) first_a = k;
    end
    check("dt10.a_rise_edge", first_a, 13);

    // Dead-time abort: leave window for 2 clocks, come back 2 clocks into DT_TO_B.
    first_a = -1; b_seen = 1'b0; both_low = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1, 1, 0, (k <= 2) ? 700 : 300, 200, 600, 10);
      if (k == 1) check("abort.a_still_on", pwm_out_a, 1);
      if (pwm_out_b) b_seen = 1'b1;
      if (!pwm_out_a && !pwm_out_b) both_low++;
      if (k >= 2 && pwm_out_a && first_a < 0) first_a = k;
    end
    check("abort.b_never", b_seen, 0);
    check("abort.a_rise_edge", first_a, 15);
    check("abort.both_low_clocks", both_low, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
